// File: rtl/dnn2ami_pkg.sv
// Shared types and helpers for the DNN-to-AMI bridge: scheduler states,
// macro write request layout and the index-width helper.
package dnn2ami_pkg;

   localparam int DNN_NUM_PU         = 2;
   localparam int DNN_AXI_ADDR_WIDTH = 32;
   localparam int DNN_AXI_DATA_WIDTH = 64;
   localparam int DNN_TX_SIZE_WIDTH  = 10;

   // Ceiling log2; returns 0 for values of 0 or 1.
   function automatic int C_LOG_2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

   localparam int DNN_NUM_PU_W = C_LOG_2(DNN_NUM_PU) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } sched_state_e;

   typedef struct packed {
      logic [DNN_AXI_ADDR_WIDTH-1:0] addr;
      logic [DNN_TX_SIZE_WIDTH-1:0]  size;
      logic [DNN_NUM_PU_W-1:0]       start_pu;
   } macro_req_t;

endpackage

// File: rtl/dnn2ami_wr_sched_if.sv
// Request, PU output buffer and AMI write port bundle of the write scheduler.
// The slave modport is the scheduler's view; master is the surrounding fabric.
interface dnn2ami_wr_sched_if import dnn2ami_pkg::*; #(
   parameter int NUM_PU         = DNN_NUM_PU,
   parameter int AXI_ADDR_WIDTH = DNN_AXI_ADDR_WIDTH,
   parameter int AXI_DATA_WIDTH = DNN_AXI_DATA_WIDTH,
   parameter int TX_SIZE_WIDTH  = DNN_TX_SIZE_WIDTH,
   parameter int NUM_PU_W       = C_LOG_2(NUM_PU) + 1
);

   logic                             req_valid;
   logic                             req_ready;
   logic [AXI_ADDR_WIDTH-1:0]        req_addr;
   logic [TX_SIZE_WIDTH-1:0]         req_size;
   logic [NUM_PU_W-1:0]              req_start_pu;
   logic [NUM_PU-1:0]                outbuf_valid;
   logic [NUM_PU*AXI_DATA_WIDTH-1:0] outbuf_data;
   logic [NUM_PU-1:0]                outbuf_pop;
   logic                             mem_wr_valid;
   logic                             mem_wr_ready;
   logic [AXI_ADDR_WIDTH-1:0]        mem_wr_addr;
   logic [AXI_DATA_WIDTH-1:0]        mem_wr_data;

   modport slave (
      input  req_valid, req_addr, req_size, req_start_pu,
      input  outbuf_valid, outbuf_data, mem_wr_ready,
      output req_ready, outbuf_pop, mem_wr_valid, mem_wr_addr, mem_wr_data
   );

   modport master (
      output req_valid, req_addr, req_size, req_start_pu,
      output outbuf_valid, outbuf_data, mem_wr_ready,
      input  req_ready, outbuf_pop, mem_wr_valid, mem_wr_addr, mem_wr_data
   );

endinterface

// File: rtl/dnn2ami_rr_ptr.sv
// Round-robin PU pointer: loads a start index, then steps modulo NUM_PU.
module dnn2ami_rr_ptr #(
   parameter int NUM_PU = 2,
   parameter int PTR_W  = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_load,
   input  logic [PTR_W-1:0] i_load_val,
   input  logic             i_adv,
   output logic [PTR_W-1:0] o_ptr
);

   localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_PU - 1);
   localparam logic [PTR_W-1:0] ONE  = PTR_W'(1);

   logic [PTR_W-1:0] r_ptr;

   // Load has priority; it only happens while the scheduler is idle anyway.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr <= '0;
      end else if (i_load) begin
         r_ptr <= i_load_val;
      end else if (i_adv) begin
         r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + ONE;
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/dnn2ami_wr_sched.sv
// Write-path scheduler: splits one macro write request into single-beat AMI
// writes, drawing beats round-robin from the per-PU output buffers.
module dnn2ami_wr_sched import dnn2ami_pkg::*; #(
   parameter int NUM_PU         = DNN_NUM_PU,
   parameter int AXI_ADDR_WIDTH = DNN_AXI_ADDR_WIDTH,
   parameter int AXI_DATA_WIDTH = DNN_AXI_DATA_WIDTH,
   parameter int TX_SIZE_WIDTH  = DNN_TX_SIZE_WIDTH,
   parameter int NUM_PU_W       = C_LOG_2(NUM_PU) + 1
) (
   input  logic                clk,
   input  logic                reset_n,
   dnn2ami_wr_sched_if.slave   bus,
   output logic                busy,
   output logic                wr_done,
   output logic                err_bad_pu
);

   localparam int                        WSTRB_W   = AXI_DATA_WIDTH / 8;
   localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_STEP = AXI_ADDR_WIDTH'(WSTRB_W);
   localparam logic [NUM_PU_W-1:0]       PU_COUNT  = NUM_PU_W'(NUM_PU);
   localparam logic [TX_SIZE_WIDTH-1:0]  SIZE_ONE  = TX_SIZE_WIDTH'(1);

   sched_state_e               r_state;
   sched_state_e               w_next;
   logic [AXI_ADDR_WIDTH-1:0]  r_addr;
   logic [TX_SIZE_WIDTH-1:0]   r_remaining;
   logic                       r_err;
   logic [NUM_PU_W-1:0]        w_pu;
   logic [NUM_PU_W-1:0]        w_load_pu;
   logic                       w_accept;
   logic                       w_bad_pu;
   logic                       w_fire;
   logic                       w_sel_valid;
   logic [AXI_DATA_WIDTH-1:0]  w_sel_data;

   // Gating with reset_n keeps req_ready low while reset is held.
   assign w_accept  = reset_n && (r_state == IDLE) && bus.req_valid;
   assign w_bad_pu  = (bus.req_start_pu >= PU_COUNT);
   assign w_load_pu = w_bad_pu ? '0 : bus.req_start_pu;
   assign w_fire    = (r_state == ISSUE) && w_sel_valid && bus.mem_wr_ready;

   dnn2ami_rr_ptr #(
      .NUM_PU (NUM_PU),
      .PTR_W  (NUM_PU_W)
   ) u_rr_ptr (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_load     (w_accept),
      .i_load_val (w_load_pu),
      .i_adv      (w_fire),
      .o_ptr      (w_pu)
   );

   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_data  = '0;
      for (int i = 0; i < NUM_PU; i++) begin
         if (w_pu == NUM_PU_W'(i)) begin
            w_sel_valid = bus.outbuf_valid[i];
            w_sel_data  = bus.outbuf_data[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (w_accept) w_next = (bus.req_size != '0) ? ISSUE : DONE;
         ISSUE:   if (w_fire && (r_remaining == SIZE_ONE)) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Address wraps naturally at the top of the address space.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_addr      <= '0;
         r_remaining <= '0;
         r_err       <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr      <= bus.req_addr;
            r_remaining <= bus.req_size;
            if (w_bad_pu) r_err <= 1'b1;
         end else if (w_fire) begin
            r_addr      <= r_addr + ADDR_STEP;
            r_remaining <= r_remaining - SIZE_ONE;
         end
      end
   end

   always_comb begin
      bus.req_ready    = w_accept;
      bus.mem_wr_valid = (r_state == ISSUE) && w_sel_valid;
      bus.mem_wr_addr  = r_addr;
      bus.mem_wr_data  = w_sel_data;
      bus.outbuf_pop   = '0;
      for (int i = 0; i < NUM_PU; i++) begin
         if (w_pu == NUM_PU_W'(i)) bus.outbuf_pop[i] = w_fire;
      end
      busy    = (r_state != IDLE);
      wr_done = (r_state == DONE);
   end

   assign err_bad_pu = r_err;

endmodule

// File: tb/tb_dnn2ami_wr_sched.sv
// Self-checking bench for dnn2ami_wr_sched: a queue-of-beats model checked
// every cycle, plus directed scenarios with hand-computed beat logs.
module tb_dnn2ami_wr_sched;

   localparam int NUM_PU = 2;

   logic clk;
   logic reset_n;
   logic busy;
   logic wr_done;
   logic err_bad_pu;

   int assertCount = 0;
   int failCount   = 0;

   dnn2ami_wr_sched_if #(.NUM_PU(NUM_PU)) bus();

   dnn2ami_wr_sched #(.NUM_PU(NUM_PU)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus),
      .busy       (busy),
      .wr_done    (wr_done),
      .err_bad_pu (err_bad_pu)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] puData(input int pu);
      return 64'hD0D0_0000_0000_0A00 + 64'(pu) * 64'h1111;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: a request becomes a list of beats; beat k goes to
   // base+8k from PU (start+k) mod NUM_PU, and the cycle after the list
   // empties is the single wr_done cycle.
   typedef struct {
      logic [31:0] addr;
      int          pu;
   } beat_t;

   beat_t       expQ[$];
   bit          doneNow = 0;
   bit          errExp = 0;
   bit          acceptF = 0;
   bit          fireF = 0;
   logic [31:0] capAddr;
   int          capSize;
   int          capPu;
   logic [31:0] logAddr[$];
   logic [63:0] logData[$];

   initial begin
      bit          idle;
      bit          eReady, eValid, eFire, doneNext;
      logic [1:0]  ePop;
      int          startPu;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            expQ.delete();
            doneNow = 0;
            errExp  = 0;
         end
         idle   = (expQ.size() == 0) && !doneNow;
         eReady = reset_n && idle && bus.req_valid;
         eValid = reset_n && (expQ.size() > 0) && bus.outbuf_valid[expQ[0].pu];
         eFire  = eValid && bus.mem_wr_ready;
         ePop   = eFire ? 2'(1 << expQ[0].pu) : 2'b00;
         checkOutput("req_ready", bus.req_ready, eReady);
         checkOutput("mem_wr_valid", bus.mem_wr_valid, eValid);
         checkOutput("outbuf_pop", bus.outbuf_pop, ePop);
         checkOutput("busy", busy, !idle);
         checkOutput("wr_done", wr_done, doneNow);
         checkOutput("err_bad_pu", err_bad_pu, errExp);
         if (eValid) begin
            checkOutput("mem_wr_addr", bus.mem_wr_addr, expQ[0].addr);
            checkOutput("mem_wr_data", bus.mem_wr_data, puData(expQ[0].pu));
         end
         if (bus.mem_wr_valid && bus.mem_wr_ready) begin
            logAddr.push_back(bus.mem_wr_addr);
            logData.push_back(bus.mem_wr_data);
         end
         acceptF = eReady;
         fireF   = eFire;
         capAddr = bus.req_addr;
         capSize = int'(bus.req_size);
         capPu   = int'(bus.req_start_pu);
         @(posedge clk);
         doneNext = 0;
         if (acceptF) begin
            startPu = (capPu >= NUM_PU) ? 0 : capPu;
            if (capPu >= NUM_PU) errExp = 1;
            for (int k = 0; k < capSize; k++)
               expQ.push_back('{addr: capAddr + 32'(k * 8), pu: (startPu + k) % NUM_PU});
            if (capSize == 0) doneNext = 1;
         end
         if (fireF) begin
            void'(expQ.pop_front());
            if (expQ.size() == 0) doneNext = 1;
         end
         doneNow = doneNext;
      end
   end

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clearLog();
      logAddr.delete();
      logData.delete();
   endtask

   // Presents a request and returns at the start of the first cycle after acceptance.
   task automatic applyStimulus(input logic [31:0] addr, input int size, input int startPu);
      bit accepted;
      accepted         = 0;
      bus.req_valid    = 1'b1;
      bus.req_addr     = addr;
      bus.req_size     = 10'(size);
      bus.req_start_pu = 2'(startPu);
      for (int c = 0; c < 20 && !accepted; c++) begin
         @(negedge clk);
         if (bus.req_ready === 1'b1) accepted = 1;
         nextCycle();
      end
      bus.req_valid = 1'b0;
      checkOutput("reqAccepted", 64'(accepted), 64'd1);
   endtask

   task automatic waitDone(input int budget);
      bit seen;
      seen = 0;
      for (int c = 0; c < budget && !seen; c++) begin
         @(negedge clk);
         if (wr_done === 1'b1) seen = 1;
         nextCycle();
      end
      checkOutput("wrDoneSeen", 64'(seen), 64'd1);
   endtask

   task automatic checkLog(input string name, input logic [31:0] addrs[$], input int pus[$]);
      checkOutput({name, "_beats"}, 64'(logAddr.size()), 64'(addrs.size()));
      for (int k = 0; k < addrs.size() && k < logAddr.size(); k++) begin
         checkOutput({name, "_addr"}, logAddr[k], addrs[k]);
         checkOutput({name, "_data"}, logData[k], puData(pus[k]));
      end
   endtask

   initial begin
      logic [1:0]  basicPop[4];
      logic [31:0] basicAddr[4];
      basicPop  = '{2'b01, 2'b10, 2'b01, 2'b10};
      basicAddr = '{32'h1000, 32'h1008, 32'h1010, 32'h1018};

      reset_n          = 1'b0;
      bus.req_valid    = 1'b1;
      bus.req_addr     = 32'h1000;
      bus.req_size     = 10'd4;
      bus.req_start_pu = 2'd0;
      bus.outbuf_valid = 2'b11;
      bus.outbuf_data  = {puData(1), puData(0)};
      bus.mem_wr_ready = 1'b1;

      repeat (3) begin
         @(negedge clk);
         checkOutput("rstReqReady", bus.req_ready, 1'b0);
         checkOutput("rstPop", bus.outbuf_pop, 2'b00);
         checkOutput("rstMemValid", bus.mem_wr_valid, 1'b0);
      end
      nextCycle();
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("acceptFirstEdge", bus.req_ready, 1'b1);
      nextCycle();
      bus.req_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkOutput("basicPop", bus.outbuf_pop, basicPop[k]);
         checkOutput("basicAddr", bus.mem_wr_addr, basicAddr[k]);
         nextCycle();
      end
      @(negedge clk);
      checkOutput("basicDone", wr_done, 1'b1);
      nextCycle();
      @(negedge clk);
      checkOutput("basicDoneOnce", wr_done, 1'b0);
      nextCycle();

      $display("[TB] backpressure");
      clearLog();
      applyStimulus(32'h1000, 4, 0);
      nextCycle();
      bus.mem_wr_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checkOutput("stallAddr", bus.mem_wr_addr, 32'h1008);
         checkOutput("stallPop", bus.outbuf_pop, 2'b00);
         nextCycle();
      end
      bus.mem_wr_ready = 1'b1;
      waitDone(20);
      checkLog("stall", '{32'h1000, 32'h1008, 32'h1010, 32'h1018}, '{0, 1, 0, 1});

      $display("[TB] stalled PU");
      clearLog();
      applyStimulus(32'h2000, 3, 1);
      bus.outbuf_valid = 2'b10;
      nextCycle();
      repeat (4) begin
         @(negedge clk);
         checkOutput("puStallValid", bus.mem_wr_valid, 1'b0);
         nextCycle();
      end
      bus.outbuf_valid = 2'b11;
      waitDone(20);
      checkLog("puStall", '{32'h2000, 32'h2008, 32'h2010}, '{1, 0, 1});

      $display("[TB] zero-size request");
      clearLog();
      applyStimulus(32'h5000, 0, 0);
      @(negedge clk);
      checkOutput("zeroDone", wr_done, 1'b1);
      nextCycle();
      @(negedge clk);
      checkOutput("zeroIdle", busy, 1'b0);
      nextCycle();
      checkOutput("zeroBeats", 64'(logAddr.size()), 64'd0);

      $display("[TB] address wrap");
      clearLog();
      applyStimulus(32'hFFFF_FFF8, 2, 0);
      waitDone(20);
      checkLog("wrap", '{32'hFFFF_FFF8, 32'h0000_0000}, '{0, 1});

      $display("[TB] bad start PU");
      clearLog();
      checkOutput("errBefore", err_bad_pu, 1'b0);
      applyStimulus(32'h6000, 2, 3);
      waitDone(20);
      checkOutput("errSticky", err_bad_pu, 1'b1);
      checkLog("badPu", '{32'h6000, 32'h6008}, '{0, 1});

      $display("[TB] reset mid-request");
      clearLog();
      applyStimulus(32'h3000, 6, 0);
      nextCycle();
      nextCycle();
      reset_n = 1'b0;
      repeat (2) begin
         @(negedge clk);
         checkOutput("midRstValid", bus.mem_wr_valid, 1'b0);
         checkOutput("midRstPop", bus.outbuf_pop, 2'b00);
         checkOutput("midRstBusy", busy, 1'b0);
         checkOutput("midRstErr", err_bad_pu, 1'b0);
         nextCycle();
      end
      reset_n = 1'b1;
      checkOutput("midRstBeats", 64'(logAddr.size()), 64'd2);
      repeat (3) begin
         @(negedge clk);
         checkOutput("midRstNoDone", wr_done, 1'b0);
         nextCycle();
      end
      clearLog();
      applyStimulus(32'h4000, 2, 1);
      waitDone(20);
      checkLog("afterRst", '{32'h4000, 32'h4008}, '{1, 0});

      repeat (2) nextCycle();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, %0d failures so far", failCount);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
